// File: rtl/pulse_train_scheduler_if.sv
// Requester handshakes, abort and serial-output signals of the pulse train scheduler.
interface pulse_train_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_pattern;
    logic [CNT_W-1:0] req0_repeat;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_pattern;
    logic [CNT_W-1:0] req1_repeat;
    logic             req1_ready;
    logic             abort;
    logic             pulse;
    logic             frame_start;
    logic             busy;
    logic             grant_id;
    logic             done;
    logic             aborted;

    modport master (
        output req0_valid, req0_pattern, req0_repeat, input req0_ready,
        output req1_valid, req1_pattern, req1_repeat, input req1_ready,
        output abort,
        input  pulse, frame_start, busy, grant_id, done, aborted
    );

    modport slave (
        input  req0_valid, req0_pattern, req0_repeat, output req0_ready,
        input  req1_valid, req1_pattern, req1_repeat, output req1_ready,
        input  abort,
        output pulse, frame_start, busy, grant_id, done, aborted
    );
endinterface

// File: rtl/pulse_train_scheduler.sv
// Round-robin arbiter plus MSB-first serializer that streams a pattern (repeat+1)
// times back-to-back, then reports done, or aborted when cancelled mid-stream.
module pulse_train_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    pulse_train_scheduler_if.slave   bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] held_pat_q, held_pat_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             grant_id_q, grant_id_d;
    logic             last_grant_q, last_grant_d;
    logic             aborted_q, aborted_d;
    logic             pick0, pick1;

    // Ready is gated by Reset_n so nothing looks accepted while reset is held.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (state_q == IDLE && Reset_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                pick0 = last_grant_q;
                pick1 = ~last_grant_q;
            end else begin
                pick0 = bus.req0_valid;
                pick1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        held_pat_d   = held_pat_q;
        rep_cnt_d    = rep_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        aborted_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick0 || pick1) begin
                    shreg_d      = pick1 ? bus.req1_pattern : bus.req0_pattern;
                    held_pat_d   = pick1 ? bus.req1_pattern : bus.req0_pattern;
                    rep_cnt_d    = pick1 ? bus.req1_repeat  : bus.req0_repeat;
                    bit_cnt_d    = '0;
                    grant_id_d   = pick1;
                    last_grant_d = pick1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bus.abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (bit_cnt_q == BW'(WIDTH - 1)) begin
                    if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - 1'b1;
                        shreg_d   = held_pat_q;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            held_pat_q   <= '0;
            rep_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            held_pat_q   <= held_pat_d;
            rep_cnt_q    <= rep_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            aborted_q    <= aborted_d;
        end
    end

    assign bus.req0_ready  = pick0;
    assign bus.req1_ready  = pick1;
    assign bus.pulse       = (state_q == SHIFT) & shreg_q[WIDTH-1];
    assign bus.frame_start = (state_q == SHIFT) & (bit_cnt_q == '0);
    assign bus.busy        = (state_q == SHIFT) | (state_q == DONE);
    assign bus.done        = (state_q == DONE);
    assign bus.grant_id    = grant_id_q;
    assign bus.aborted     = aborted_q;
endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Directed bench for pulse_train_scheduler: reset, single and repeated jobs,
// alternating grants, abort and mid-job reset, each against hand-derived values.
module tb_pulse_train_scheduler;
    logic Clk;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] p6;

    pulse_train_scheduler_if #(.WIDTH(8), .CNT_W(4)) bus ();

    pulse_train_scheduler #(.WIDTH(8), .CNT_W(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in the first pulse cycle after accept; leaves in the IDLE cycle after DONE.
    task automatic run_job(input logic id, input logic [7:0] pat, input int rep, input string name);
        for (int f = 0; f <= rep; f++) begin
            for (int b = 0; b < 8; b++) begin
                chk({name, " pulse"}, 32'(bus.pulse), 32'(pat[7-b]));
                chk({name, " frame_start"}, 32'(bus.frame_start), 32'(b == 0));
                chk({name, " busy"}, 32'(bus.busy), 32'd1);
                chk({name, " done_early"}, 32'(bus.done), 32'd0);
                chk({name, " ready_busy"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
                if (f == 0 && b == 0) chk({name, " grant_id"}, 32'(bus.grant_id), 32'(id));
                step();
            end
        end
        chk({name, " done"}, 32'(bus.done), 32'd1);
        chk({name, " done_pulse"}, 32'(bus.pulse), 32'd0);
        chk({name, " done_busy"}, 32'(bus.busy), 32'd1);
        chk({name, " done_fs"}, 32'(bus.frame_start), 32'd0);
        step();
        chk({name, " idle_done"}, 32'(bus.done), 32'd0);
        chk({name, " idle_busy"}, 32'(bus.busy), 32'd0);
        chk({name, " idle_grant"}, 32'(bus.grant_id), 32'(id));
        $display("job %s grant=%0d pattern=%02h repeat=%0d checks=%0d errors=%0d",
                 name, id, pat, rep, checks, errors);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        Reset_n          = 1'b0;
        bus.req0_valid   = 1'b1;
        bus.req0_pattern = 8'hA5;
        bus.req0_repeat  = 4'd0;
        bus.req1_valid   = 1'b1;
        bus.req1_pattern = 8'h81;
        bus.req1_repeat  = 4'd2;
        bus.abort        = 1'b0;
        p6               = 8'h0F;

        // Reset held two edges with both requesters valid
        step();
        step();
        chk("rst ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst ready1", 32'(bus.req1_ready), 32'd0);
        chk("rst pulse", 32'(bus.pulse), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst aborted", 32'(bus.aborted), 32'd0);
        chk("rst grant", 32'(bus.grant_id), 32'd0);
        Reset_n = 1'b1;
        #1;
        chk("first ready0", 32'(bus.req0_ready), 32'd1);
        chk("first ready1", 32'(bus.req1_ready), 32'd0);
        step();
        bus.req0_valid = 1'b0;
        run_job(1'b0, 8'hA5, 0, "A5r0");

        chk("t3 ready1", 32'(bus.req1_ready), 32'd1);
        chk("t3 ready0", 32'(bus.req0_ready), 32'd0);
        step();
        bus.req1_valid = 1'b0;
        run_job(1'b1, 8'h81, 2, "81r2");

        // Both requesters continuously valid: grants alternate 0,1,0,1
        bus.req0_valid   = 1'b1;
        bus.req0_pattern = 8'h3C;
        bus.req0_repeat  = 4'd0;
        bus.req1_valid   = 1'b1;
        bus.req1_pattern = 8'hC6;
        bus.req1_repeat  = 4'd0;
        #1;
        chk("rr0 ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        step();
        run_job(1'b0, 8'h3C, 0, "rr0");
        chk("rr1 ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
        step();
        run_job(1'b1, 8'hC6, 0, "rr1");
        chk("rr2 ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        step();
        run_job(1'b0, 8'h3C, 0, "rr2");
        chk("rr3 ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
        step();
        run_job(1'b1, 8'hC6, 0, "rr3");
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Abort at the third bit cycle of an FF x4 job
        bus.req0_valid   = 1'b1;
        bus.req0_pattern = 8'hFF;
        bus.req0_repeat  = 4'd3;
        #1;
        chk("ab ready0", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid   = 1'b0;
        bus.req1_valid   = 1'b1;
        bus.req1_pattern = 8'h5A;
        bus.req1_repeat  = 4'd1;
        chk("ab c1 pulse", 32'(bus.pulse), 32'd1);
        chk("ab c1 grant", 32'(bus.grant_id), 32'd0);
        step();
        chk("ab c2 pulse", 32'(bus.pulse), 32'd1);
        step();
        chk("ab c3 pulse", 32'(bus.pulse), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        #1;
        chk("ab pulse", 32'(bus.pulse), 32'd0);
        chk("ab aborted", 32'(bus.aborted), 32'd1);
        chk("ab done", 32'(bus.done), 32'd0);
        chk("ab busy", 32'(bus.busy), 32'd0);
        chk("ab ready1", 32'(bus.req1_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        chk("ab aborted_clr", 32'(bus.aborted), 32'd0);
        chk("ab no_done", 32'(bus.done), 32'd0);
        run_job(1'b1, 8'h5A, 1, "5Ar1");

        // Reset during frame 2 of a repeat-1 job with req1 still valid
        bus.req1_valid   = 1'b1;
        bus.req1_pattern = 8'h0F;
        bus.req1_repeat  = 4'd1;
        #1;
        chk("mr ready1", 32'(bus.req1_ready), 32'd1);
        step();
        for (int c = 1; c <= 9; c++) begin
            chk("mr pulse", 32'(bus.pulse), 32'(p6[7 - ((c - 1) % 8)]));
            chk("mr frame_start", 32'(bus.frame_start), 32'(((c - 1) % 8) == 0));
            step();
        end
        Reset_n          = 1'b0;
        bus.req0_valid   = 1'b1;
        bus.req0_pattern = 8'h99;
        bus.req0_repeat  = 4'd0;
        step();
        chk("mr rst pulse", 32'(bus.pulse), 32'd0);
        chk("mr rst busy", 32'(bus.busy), 32'd0);
        chk("mr rst done", 32'(bus.done), 32'd0);
        chk("mr rst aborted", 32'(bus.aborted), 32'd0);
        chk("mr rst ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b00);
        chk("mr rst grant", 32'(bus.grant_id), 32'd0);
        Reset_n = 1'b1;
        #1;
        chk("mr post ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        step();
        bus.req0_valid = 1'b0;
        run_job(1'b0, 8'h99, 0, "99r0");
        chk("mr req1 ready", 32'(bus.req1_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        run_job(1'b1, 8'h0F, 1, "0Fr1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
